// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared CPU fetch types: buffered instruction entry, reset vector and the
// ibus request/response bundles used by the fetch front end.
package fetch_prefetch_unit_pkg;

    localparam logic [31:0] CPU_RESET_PC = 32'hbfc0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hffff_fffc;
    endfunction

endpackage

// File: rtl/fetch_prefetch_unit_checker.sv
// Invariants of the fetch front end: credit accounting must keep the
// instruction buffer and in-flight PC queue from overflowing.
module fetch_prefetch_unit_checker #(
    parameter int unsigned OW = 2
) (
    input logic          clk,
    input logic          resetn,
    input logic          i_buf_overflow,
    input logic          i_pcq_overflow,
    input logic          i_resp_underflow,
    input logic [OW-1:0] i_pcq_count,
    input logic [OW-1:0] i_outstanding
);
    a_buf_no_overflow: assert property (@(posedge clk) disable iff (!resetn) !i_buf_overflow);
    a_pcq_no_overflow: assert property (@(posedge clk) disable iff (!resetn) !i_pcq_overflow);
    a_no_stray_resp:   assert property (@(posedge clk) disable iff (!resetn) !i_resp_underflow);
    a_pcq_tracks:      assert property (@(posedge clk) disable iff (!resetn) i_pcq_count == i_outstanding);
endmodule

// File: rtl/fetch_prefetch_unit_sync_fifo.sv
// Synchronous FIFO with flush; depth need not be a power of two.
// Same-cycle push and pop are accepted when full.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_overflow
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? {AW{1'b0}} : ptr + AW'(1);
    endfunction

    assign w_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == {CW{1'b0}});
    assign w_pop      = i_pop & ~o_empty & ~i_flush;
    assign w_push     = i_push & ~i_flush & (~w_full | w_pop);
    assign o_overflow = i_push & ~i_flush & w_full & ~w_pop;
    assign o_rdata    = r_mem[r_rd];
    assign o_count    = r_count;

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (!resetn || i_flush) begin
            r_wr    <= {AW{1'b0}};
            r_rd    <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            r_wr    <= w_push ? ptr_next(r_wr) : r_wr;
            r_rd    <= w_pop ? ptr_next(r_rd) : r_rd;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_wdata;
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Pipelined instruction prefetch: issues up to MAX_OUTSTANDING ibus requests,
// buffers up to DEPTH {pc,instr} entries, and discards stale data on redirect.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = CPU_RESET_PC
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready
);
    localparam int unsigned BW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CW = BW + 1;
    localparam int unsigned EW = $bits(fetch_entry_t);

    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_hold_addr;
    logic         r_pending;
    logic         r_rdp;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_discard;

    logic [CW-1:0] w_occ;
    logic          w_req_valid;
    logic          w_acc;
    logic          w_push;
    logic          w_pop;
    logic [OW-1:0] w_out_next;
    logic [OW-1:0] w_discard_dec;
    logic [OW-1:0] w_discard_next;
    logic [BW-1:0] w_buf_count;
    logic          w_buf_empty;
    logic          w_buf_overflow;
    logic [EW-1:0] w_buf_rdata;
    logic [31:0]   w_pcq_rdata;
    logic          w_pcq_empty;
    logic [OW-1:0] w_pcq_count;
    logic          w_pcq_overflow;
    fetch_entry_t  w_head;
    fetch_entry_t  w_new_entry;

    // Credit covers buffered entries plus every in-flight request, so a
    // response we keep always finds a free buffer slot.
    assign w_occ       = CW'(w_buf_count) + CW'(r_outstanding);
    assign w_req_valid = resetn & (r_pending |
                         ((w_occ < CW'(DEPTH)) & (r_outstanding < OW'(MAX_OUTSTANDING))));
    assign ireq_valid  = w_req_valid;
    assign ireq_addr   = r_pending ? r_hold_addr : r_fetch_pc;
    assign w_acc       = w_req_valid & iresp_addr_ok;

    assign w_push = iresp_data_ok & (r_discard == {OW{1'b0}}) & ~redirect_valid;
    assign w_pop  = out_valid & out_ready & ~redirect_valid;

    // Redirect discards everything still in flight after this cycle's
    // accept/response; a held request accepted later adds one more.
    assign w_out_next     = r_outstanding + OW'(w_acc) - OW'(iresp_data_ok);
    assign w_discard_dec  = (iresp_data_ok && (r_discard != {OW{1'b0}})) ? r_discard - OW'(1) : r_discard;
    assign w_discard_next = redirect_valid ? w_out_next : (w_discard_dec + OW'(w_acc & r_rdp));

    // Issue, request-hold and redirect control state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_fetch_pc    <= RESET_PC;
            r_hold_addr   <= 32'h0000_0000;
            r_pending     <= 1'b0;
            r_rdp         <= 1'b0;
            r_outstanding <= {OW{1'b0}};
            r_discard     <= {OW{1'b0}};
        end else begin
            r_pending     <= w_req_valid & ~iresp_addr_ok;
            r_hold_addr   <= (w_req_valid && !iresp_addr_ok) ? ireq_addr : r_hold_addr;
            r_rdp         <= w_req_valid & ~iresp_addr_ok & (r_rdp | redirect_valid);
            r_outstanding <= w_out_next;
            r_discard     <= w_discard_next;
            if (redirect_valid) begin
                r_fetch_pc <= word_align(redirect_pc);
            end else if (w_acc && !r_rdp) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end else begin
                r_fetch_pc <= r_fetch_pc;
            end
        end
    end

    sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pc_queue (
        .clk        (clk),
        .resetn     (resetn),
        .i_flush    (1'b0),
        .i_push     (w_acc),
        .i_wdata    (ireq_addr),
        .i_pop      (iresp_data_ok),
        .o_rdata    (w_pcq_rdata),
        .o_empty    (w_pcq_empty),
        .o_count    (w_pcq_count),
        .o_overflow (w_pcq_overflow)
    );

    assign w_new_entry.pc    = w_pcq_rdata;
    assign w_new_entry.instr = iresp_data;

    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_buf (
        .clk        (clk),
        .resetn     (resetn),
        .i_flush    (redirect_valid),
        .i_push     (w_push),
        .i_wdata    (w_new_entry),
        .i_pop      (w_pop),
        .o_rdata    (w_buf_rdata),
        .o_empty    (w_buf_empty),
        .o_count    (w_buf_count),
        .o_overflow (w_buf_overflow)
    );

    assign w_head    = w_buf_rdata;
    assign out_valid = ~w_buf_empty;
    assign out_pc    = out_valid ? w_head.pc : 32'h0000_0000;
    assign out_instr = out_valid ? w_head.instr : 32'h0000_0000;

    fetch_prefetch_unit_checker #(.OW(OW)) u_checker (
        .clk              (clk),
        .resetn           (resetn),
        .i_buf_overflow   (w_buf_overflow),
        .i_pcq_overflow   (w_pcq_overflow),
        .i_resp_underflow (iresp_data_ok & w_pcq_empty),
        .i_pcq_count      (w_pcq_count),
        .i_outstanding    (r_outstanding)
    );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench for fetch_prefetch_unit: a randomized in-order ibus model
// feeds the DUT; an epoch-tagged reference model predicts delivered entries.
module tb_fetch_prefetch_unit;
    localparam int          DEPTH    = 4;
    localparam int          MAXO     = 2;
    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_addr_ok = 1'b0;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;

    fetch_prefetch_unit #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_addr_ok  (iresp_addr_ok),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // ---------------- reference model state ----------------
    int          epoch = 0;
    int          cur_tag = 0;
    int          tq[$];
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] mf = RESET_PC;
    logic [31:0] held = 32'h0;
    bit          m_pending = 1'b0;
    logic        rst_q;

    always @(posedge clk) rst_q <= resetn;

    // Monitor: request-side rules and buffer head compared against model state.
    always @(negedge clk) begin
        if (!resetn) begin
            if (rst_q == 1'b0) begin
                check("rst_ireq_valid", 64'(ireq_valid), 64'd0);
                check("rst_out_valid", 64'(out_valid), 64'd0);
                check("rst_out_head", {out_pc, out_instr}, 64'd0);
            end
        end else begin
            check("ireq_valid", 64'(ireq_valid),
                  64'(m_pending || ((exp_q.size() + tq.size() < DEPTH) && (tq.size() < MAXO))));
            if (ireq_valid) begin
                if (m_pending) check("req_hold", 64'(ireq_addr), 64'(held));
                else           check("req_addr", 64'(ireq_addr), 64'(mf));
            end
            check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0) begin
                check("out_head", {out_pc, out_instr}, exp_q[0]);
                if (out_ready && !redirect_valid) void'(exp_q.pop_front());
            end
        end
    end

    // Reference model: requests carry the redirect epoch they were issued in;
    // only responses of the current epoch become buffered instructions.
    always begin
        @(negedge clk);
        #1;
        if (!resetn) begin
            epoch = 0; cur_tag = 0; tq.delete(); exp_q.delete();
            mf = RESET_PC; exp_pc = RESET_PC; m_pending = 1'b0;
        end else begin
            if (ireq_valid && !m_pending) begin
                cur_tag = epoch;
                held    = ireq_addr;
            end
            if (ireq_valid && iresp_addr_ok) begin
                tq.push_back(cur_tag);
                if (cur_tag == epoch) mf = mf + 32'd4;
            end
            m_pending = ireq_valid && !iresp_addr_ok;
            if (iresp_data_ok && tq.size() != 0) begin
                int t;
                t = tq.pop_front();
                if (t == epoch && !redirect_valid) begin
                    exp_q.push_back({exp_pc, mem_word(exp_pc)});
                    exp_pc = exp_pc + 32'd4;
                end
            end
            if (redirect_valid) begin
                epoch++;
                exp_q.delete();
                mf     = redirect_pc & 32'hffff_fffc;
                exp_pc = mf;
            end
        end
    end

    // ---------------- ibus model and stimulus ----------------
    logic [31:0] bus_a[$];
    int          bus_t[$];
    int          cyc = 0;
    int          n_acc = 0;
    int          max_out = 0;
    int          p_aok = 100, p_dok = 100, p_rdy = 100, p_redir = 0, delay = 1;

    task automatic step();
        @(negedge clk);
        if (!resetn) begin
            bus_a.delete();
            bus_t.delete();
        end else begin
            if (ireq_valid && iresp_addr_ok) begin
                bus_a.push_back(ireq_addr);
                bus_t.push_back(cyc);
                n_acc++;
            end
            if (iresp_data_ok && bus_a.size() != 0) begin
                void'(bus_a.pop_front());
                void'(bus_t.pop_front());
            end
            if (bus_a.size() > max_out) max_out = bus_a.size();
        end
        @(posedge clk);
        #1;
        cyc++;
        iresp_addr_ok = ($urandom_range(99) < p_aok);
        iresp_data_ok = 1'b0;
        iresp_data    = $urandom;
        if (resetn && bus_a.size() != 0) begin
            if ((cyc - bus_t[0] >= delay) && ($urandom_range(99) < p_dok)) begin
                iresp_data_ok = 1'b1;
                iresp_data    = mem_word(bus_a[0]);
            end
        end
        out_ready      = ($urandom_range(99) < p_rdy);
        redirect_valid = ($urandom_range(99) < p_redir);
        redirect_pc    = $urandom;
    endtask

    task automatic do_reset(input int cycles);
        resetn = 1'b0;
        repeat (cycles) step();
        resetn = 1'b1;
    endtask

    initial begin
        int k;
        do_reset(3);

        // Streaming: bus always ready, data one cycle after accept.
        repeat (40) step();

        // Consumer stalled: buffer fills to DEPTH and issue stops.
        do_reset(2);
        n_acc = 0;
        p_rdy = 0;
        repeat (15) step();
        check("stall_accepts", 64'(n_acc), 64'd4);
        check("stall_no_issue", 64'(ireq_valid), 64'd0);
        p_rdy = 100;
        repeat (15) step();

        // Slow responses: outstanding saturates at MAX_OUTSTANDING.
        delay = 5;
        max_out = 0;
        repeat (40) step();
        check("max_outstanding", 64'(max_out), 64'(MAXO));

        // Directed redirect with two requests in flight and an entry buffered.
        delay = 4;
        p_rdy = 0;
        k = 0;
        while (!(bus_a.size() == 2 && exp_q.size() >= 1) && k < 40) begin
            step();
            k++;
        end
        check("redirect_setup", 64'(bus_a.size() == 2 && exp_q.size() >= 1), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        step();
        p_rdy = 100;
        delay = 1;
        repeat (30) step();

        // Randomized traffic with redirects, stalls and occasional reset.
        p_aok = 60; p_dok = 50; p_rdy = 70; p_redir = 5;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499) == 0) do_reset(2);
            else step();
        end
        p_redir = 0; p_rdy = 100; p_aok = 100; p_dok = 100;
        repeat (30) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Parametrised instruction-fetch front end for the multi-cycle CPU; replaces the single-request fetch state.
- Keeps up to MAX_OUTSTANDING pipelined ibus requests in flight and buffers up to DEPTH fetched instructions, each tagged with its PC.
- Supports redirect (branch/exception) with flush and discard of stale responses.
- Sits between the ibus interface and the decode/commit sequencer.

Parameters:
- DEPTH, 4, instruction buffer entries; power of 2, ≥2.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered ibus requests; ≥1, ≤DEPTH.
- RESET_PC, 32'hbfc0_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- ireq_valid  out  1  ibus request valid.
- ireq_addr  out  32  ibus request address.
- iresp_addr_ok  in  1  request accepted this cycle.
- iresp_data_ok  in  1  response data valid this cycle; responses arrive in order.
- iresp_data  in  32  instruction word.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and treated as 0.
- out_valid  out  1  buffer head valid.
- out_pc  out  32  PC of head instruction.
- out_instr  out  32  head instruction word.
- out_ready  in  1  consumer pops head when out_valid & out_ready.

Behaviour:
- Reset (resetn=0 at posedge) clears all state:
  - fetch_pc=RESET_PC; buffer empty; outstanding=0; discard=0; pending=0.
  - Outputs during and immediately after reset: ireq_valid=0, out_valid=0, out_pc/out_instr=0.
  - Reset mid-transaction drops all in-flight state. The bus side is reset in the same domain.
- Issue:
  - ireq_valid=1 when pending=1, or when (buffered + outstanding) < DEPTH and outstanding < MAX_OUTSTANDING.
  - ireq_addr=fetch_pc.
  - The first request appears in the first cycle with resetn=1.
- Request stability:
  - Once ireq_valid=1 and addr_ok=0, the pending flag is set.
  - ireq_valid and ireq_addr are held unchanged until addr_ok, including across redirect.
- Accept (ireq_valid & addr_ok):
  - Push fetch_pc into the in-flight PC queue (MAX_OUTSTANDING deep); outstanding+1; pending=0.
  - fetch_pc+=4, wrapping modulo 2^32.
- Response (data_ok):
  - Pop the in-flight PC queue; outstanding-1.
  - If discard>0: drop the word and discard-1.
  - Else: push {pc,data} into the buffer, visible on out_* the next cycle (1-cycle latency data_ok→out_valid).
- Credit accounting guarantees a non-discarded response never meets a full buffer. An overflow is an assertion failure.
- Pop: out_valid & out_ready removes the head; same-cycle push and pop are allowed at full and at empty.
- Redirect (redirect_valid=1):
  - Next cycle: buffer empty, out_valid=0.
  - discard = outstanding after this cycle's accept/response (same-cycle accept counts; same-cycle response is dropped).
  - fetch_pc=redirect_pc.
  - Same-cycle pop or push is overridden.
- Redirect while pending, not yet accepted:
  - Keep the old request until addr_ok; that request is counted into discard.
  - fetch_pc for the next request is redirect_pc.
  - Track this with a redirect_during_pending flag.
- Back-to-back redirects: the last one wins; discard is never decremented below 0.
- Counters are clog2(MAX_OUTSTANDING+1) and clog2(DEPTH+1) bits wide, with no wrap.
- No branch prediction and no alignment fault; exceptions are handled downstream.

Decomposition:
- Shared CPU package:
  - fetch_entry_t {pc, instr}.
  - RESET_PC constant; reuse the existing ibus req/resp typedefs for an optional struct wrapper.
- Sub-module sync_fifo, parametrised by width and depth, with flush input.
  - Instantiated twice: instruction buffer (fetch_entry_t, DEPTH) and in-flight PC queue (32, MAX_OUTSTANDING).
- Top contains only the issue/pending/discard control.

Test Plan:
- Reset then addr_ok=1 every cycle, data_ok 1 cycle after accept, out_ready=1
  -> out_pc sequence bfc00000, bfc00004, bfc00008…, instr matches memory model; first out_valid 3 cycles after reset release.
- out_ready=0, bus always ready
  -> exactly 4 requests accepted (DEPTH=4), ireq_valid=0 thereafter, buffer full; release out_ready -> 4 in-order pops, then fetching resumes.
- data_ok delayed 5 cycles
  -> never more than 2 accepted unanswered; ireq_valid drops while outstanding=2.
- Redirect to 80000100 with 2 outstanding and 1 buffered
  -> next cycle out_valid=0; both responses dropped; first delivered out_pc=80000100.
- Redirect while ireq_valid=1 and addr_ok=0 at addr X
  -> ireq_addr stays X until addr_ok; its data is discarded; next request is redirect_pc.
- Redirect in the same cycle as data_ok, pop and addr_ok
  -> response dropped, accepted request discarded, no entry delivered until redirect target data returns.
